// File: rtl/a23_gc_run_ctrl.sv
// rtl/a23_gc_run_ctrl.sv - run controller: core reset sequencing, cycle counting, output memory dump
module a23_gc_run_ctrl #(
    parameter int OUT_MEM_SIZE = 64,
    parameter int RST_CYCLES   = 3,
    parameter int CC_WIDTH     = 32,
    parameter int MAX_CYCLES   = 1000000,
    localparam int IW = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     core_rst,
    input  logic                     core_terminate,
    input  logic [OUT_MEM_SIZE*32-1:0] core_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [IW-1:0]            out_index,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CC_WIDTH-1:0]      cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]      RC_LOAD  = RCW'(RST_CYCLES - 1);
    localparam logic [CC_WIDTH-1:0] CC_LIMIT = CC_WIDTH'(MAX_CYCLES);
    localparam logic [IW-1:0]       LAST_IDX = IW'(OUT_MEM_SIZE - 1);

    state_t              state, state_next;
    logic [RCW-1:0]      rst_cnt, rst_cnt_next;
    logic                core_rst_next;
    logic                out_valid_next;
    logic [31:0]         out_data_next;
    logic [IW-1:0]       out_index_next;
    logic                busy_next;
    logic                done_next;
    logic                timeout_next;
    logic [CC_WIDTH-1:0] cycle_count_next;

    logic [31:0]         snap [OUT_MEM_SIZE];
    logic                capture;
    logic                timeout_hit;
    logic [IW-1:0]       idx_inc;

    assign timeout_hit = (MAX_CYCLES != 0) && (cycle_count >= CC_LIMIT);
    assign capture     = (state == S_RUN) && (core_terminate || timeout_hit);
    assign idx_inc     = out_index + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            core_rst    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            rst_cnt     <= rst_cnt_next;
            core_rst    <= core_rst_next;
            out_valid   <= out_valid_next;
            out_data    <= out_data_next;
            out_index   <= out_index_next;
            busy        <= busy_next;
            done        <= done_next;
            timeout     <= timeout_next;
            cycle_count <= cycle_count_next;
        end
    end

    // Snapshot contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < OUT_MEM_SIZE; i++) begin
                snap[i] <= core_o[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_next       = state;
        rst_cnt_next     = rst_cnt;
        core_rst_next    = core_rst;
        out_valid_next   = out_valid;
        out_data_next    = out_data;
        out_index_next   = out_index;
        busy_next        = busy;
        done_next        = done;
        timeout_next     = timeout;
        cycle_count_next = cycle_count;

        case (state)
            S_IDLE, S_DONE: begin
                core_rst_next = 1'b1;
                if (start) begin
                    state_next       = S_RESET;
                    rst_cnt_next     = RC_LOAD;
                    cycle_count_next = '0;
                    timeout_next     = 1'b0;
                    done_next        = 1'b0;
                    busy_next        = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt == '0) begin
                    state_next    = S_RUN;
                    core_rst_next = 1'b0;
                end else begin
                    rst_cnt_next = rst_cnt - 1'b1;
                end
            end
            S_RUN: begin
                // Terminate takes priority over a coincident timeout.
                if (capture) begin
                    state_next     = S_DRAIN;
                    core_rst_next  = 1'b1;
                    out_valid_next = 1'b1;
                    out_index_next = '0;
                    out_data_next  = core_o[31:0];
                    timeout_next   = !core_terminate;
                end else if (cycle_count != {CC_WIDTH{1'b1}}) begin
                    cycle_count_next = cycle_count + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (out_index == LAST_IDX) begin
                        state_next     = S_DONE;
                        out_valid_next = 1'b0;
                        out_index_next = '0;
                        done_next      = 1'b1;
                        busy_next      = 1'b0;
                    end else begin
                        out_index_next = idx_inc;
                        out_data_next  = snap[idx_inc];
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_a23_gc_run_ctrl.sv
// tb/tb_a23_gc_run_ctrl.sv - scoreboard bench for a23_gc_run_ctrl
module tb_a23_gc_run_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         core_rst;
    logic         core_terminate;
    logic [127:0] core_o;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_index;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [31:0]  cycle_count;

    a23_gc_run_ctrl #(
        .OUT_MEM_SIZE(4),
        .RST_CYCLES  (3),
        .CC_WIDTH    (32),
        .MAX_CYCLES  (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .core_rst      (core_rst),
        .core_terminate(core_terminate),
        .core_o        (core_o),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          xfers = 0;
    int          low_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_idx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        exp_q.push_back('{32'd0, w0});
        exp_q.push_back('{32'd1, w1});
        exp_q.push_back('{32'd2, w2});
        exp_q.push_back('{32'd3, w3});
    endtask

    // Monitor: pops the scoreboard on every accepted word, checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (!core_rst && !core_terminate) low_cnt++;
            if (held && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_index", 32'(out_index), 32'(prev_idx));
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("word_index", 32'(out_index), e.idx);
                    check("word_data", out_data, e.data);
                end
            end
            held      = out_valid && !out_ready;
            prev_data = out_data;
            prev_idx  = out_index;
        end
    end

    function automatic logic cond(input int sel);
        case (sel)
            0:       return core_rst == 1'b0;
            1:       return out_valid == 1'b1;
            2:       return done == 1'b1;
            3:       return cycle_count == 32'd5;
            default: return 1'b0;
        endcase
    endfunction

    // Polls #1 after each rising edge; n counts edges waited.
    task automatic wait_until(input int sel, input string name, input int limit, output int n);
        n = 0;
        while (!cond(sel) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cond(sel)) check({name, "_wait"}, 32'(cond(sel)), 32'd1);
    endtask

    task automatic start_run;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_term(input int k, input string name);
        int n;
        wait_until(0, {name, "_rst_fall"}, 20, n);
        repeat (k) @(posedge clk);
        #1 core_terminate = 1'b1;
        @(posedge clk);
        #1 core_terminate = 1'b0;
        check({name, "_valid_rise"}, 32'(out_valid), 32'd1);
    endtask

    task automatic finish_run(input logic [31:0] cc, input logic to, input string name);
        int n;
        wait_until(2, {name, "_done"}, 60, n);
        check({name, "_cycle_count"}, cycle_count, cc);
        check({name, "_timeout"}, 32'(timeout), 32'(to));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_core_rst"}, 32'(core_rst), 32'd1);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int x0;
        int l0;
        logic [6:0] pat;

        rst = 1'b1;
        start = 1'b0;
        core_terminate = 1'b0;
        out_ready = 1'b1;
        core_o = {32'd4, 32'd3, 32'd2, 32'd1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        rst = 1'b0;

        // Normal run: terminate sampled at E0+11, cycle_count 10.
        push4(32'd1, 32'd2, 32'd3, 32'd4);
        x0 = xfers;
        l0 = low_cnt;
        start_run();
        check("norm_busy", 32'(busy), 32'd1);
        check("norm_core_rst_t", 32'(core_rst), 32'd1);
        repeat (2) @(posedge clk);
        #1 check("norm_core_rst_t2", 32'(core_rst), 32'd1);
        @(posedge clk);
        #1 check("norm_core_rst_t3", 32'(core_rst), 32'd0);
        do_term(10, "norm");
        wait_until(2, "norm_dump", 20, n);
        check("norm_dump_edges", 32'(n), 32'd4);
        finish_run(32'd10, 1'b0, "norm");
        check("norm_done", 32'(done), 32'd1);
        check("norm_xfers", 32'(xfers - x0), 32'd4);
        check("norm_core_low", 32'(low_cnt - l0), 32'd10);

        // Backpressure with out_ready pattern 1,0,0,1,0,1,1.
        push4(32'd1, 32'd2, 32'd3, 32'd4);
        x0 = xfers;
        pat = 7'b1101001;
        out_ready = 1'b0;
        start_run();
        do_term(10, "bp");
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 6) check("bp_done_early", 32'(done), 32'd0);
            out_ready = pat[i];
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        check("bp_done", 32'(done), 32'd1);
        finish_run(32'd10, 1'b0, "bp");
        check("bp_xfers", 32'(xfers - x0), 32'd4);

        // Timeout: never terminate.
        push4(32'd1, 32'd2, 32'd3, 32'd4);
        start_run();
        wait_until(0, "to_rst_fall", 20, n);
        wait_until(1, "to_valid", 40, n);
        check("to_valid_edges", 32'(n), 32'd21);
        check("to_flag_at_valid", 32'(timeout), 32'd1);
        finish_run(32'd20, 1'b1, "to");

        // Terminate on the same edge the timeout would fire.
        push4(32'd1, 32'd2, 32'd3, 32'd4);
        start_run();
        do_term(20, "sim");
        finish_run(32'd20, 1'b0, "sim");

        // Start held high through RUN and DRAIN.
        core_o = {32'hD, 32'hC, 32'hB, 32'hA};
        push4(32'hA, 32'hB, 32'hC, 32'hD);
        start_run();
        wait_until(0, "hold_rst_fall", 20, n);
        start = 1'b1;
        do_term(5, "hold");
        check("hold_busy_drain", 32'(busy), 32'd1);
        wait_until(2, "hold_done", 20, n);
        start = 1'b0;
        check("hold_cycle_count", cycle_count, 32'd5);
        @(posedge clk);
        #1 check("hold_done_stays", 32'(done), 32'd1);

        // Restart from DONE refreshes snapshot.
        core_o = {32'd8, 32'd7, 32'd6, 32'd5};
        push4(32'd5, 32'd6, 32'd7, 32'd8);
        start_run();
        check("re_done_clr", 32'(done), 32'd0);
        check("re_cc_clr", cycle_count, 32'd0);
        check("re_busy", 32'(busy), 32'd1);
        do_term(3, "re");
        finish_run(32'd3, 1'b0, "re");

        // Reset mid-RUN.
        start_run();
        wait_until(0, "mr_rst_fall", 20, n);
        wait_until(3, "mr_cc5", 20, n);
        rst = 1'b1;
        #1;
        check("mr_core_rst", 32'(core_rst), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cycle_count", cycle_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-DRAIN at out_index 2.
        push4(32'd5, 32'd6, 32'd7, 32'd8);
        out_ready = 1'b0;
        start_run();
        do_term(4, "md");
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        check("md_index", 32'(out_index), 32'd2);
        check("md_data", out_data, 32'd7);
        rst = 1'b1;
        #1;
        check("md_out_valid", 32'(out_valid), 32'd0);
        check("md_out_index", 32'(out_index), 32'd0);
        check("md_out_data", out_data, 32'd0);
        check("md_busy", 32'(busy), 32'd0);
        check("md_core_rst", 32'(core_rst), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Clean run after reset.
        push4(32'd5, 32'd6, 32'd7, 32'd8);
        start_run();
        do_term(10, "post");
        finish_run(32'd10, 1'b0, "post");
        check("post_done", 32'(done), 32'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
